// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - decode-stage load-use hazard scoreboard
// Optional stall cycle counter enabled by SCOREBOARD_STATS_EN.
module load_use_scoreboard #(
  parameter  int NUM_REGS = 16,
  parameter  int CNT_W    = 2,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [IDX_W-1:0]    id_rs1,
  input  logic [IDX_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_is_load,
  input  logic [IDX_W-1:0]    id_reg_dst,
  input  logic                ex_hold,
  input  logic                wb_load_wr,
  input  logic [IDX_W-1:0]    wb_dst,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] pending_mask,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic                overflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                raw1;
  logic                raw2;
  logic                full;

  // A load retiring as the last pending one is picked up by the decode bypass.
  always_comb begin
    raw1  = id_use_rs1 && (cnt[id_rs1] != '0) &&
            !(wb_load_wr && (wb_dst == id_rs1) && (cnt[id_rs1] == CNT_ONE));
    raw2  = id_use_rs2 && (cnt[id_rs2] != '0) &&
            !(wb_load_wr && (wb_dst == id_rs2) && (cnt[id_rs2] == CNT_ONE));
    full  = id_is_load && (cnt[id_reg_dst] == CNT_MAX) &&
            !(wb_load_wr && (wb_dst == id_reg_dst));
    stall = id_valid && (raw1 || raw2 || full);
    issue = id_valid && !stall && !ex_hold;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i]      = issue && id_is_load && (id_reg_dst == IDX_W'(i));
      dec_vec[i]      = wb_load_wr && (wb_dst == IDX_W'(i));
      pending_mask[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Any retire against an empty counter means the pipeline lost track of a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (|(dec_vec & ~pending_mask)) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Hazard controller for the decode stage.
- Tracks in-flight load destinations per architectural register (16 regs, 4-bit indices) from issue in decode until the load result is written back.
- Stalls decode when an instruction reads a register whose load value cannot yet be forwarded.
- ALU results are covered by the EX forward unit and the decode write-back bypass, so only loads are scoreboarded.

Parameters:
- NUM_REGS, 16, number of architectural registers; index width is log2(NUM_REGS) = 4.
- CNT_W, 2, width of each per-register pending-load counter; max in-flight loads per register = 2^CNT_W - 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  valid instruction present in decode
- id_rs1  input  4  source register 1 index
- id_rs2  input  4  source register 2 index
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_is_load  input  1  instruction is a load with register write
- id_reg_dst  input  4  destination register index
- ex_hold  input  1  downstream pipeline hold; no issue this cycle
- wb_load_wr  input  1  write-back stage is retiring a load result this cycle
- wb_dst  input  4  destination register of the retiring load
- stall  output  1  decode must hold its instruction (combinational)
- issue  output  1  instruction leaves decode this cycle (combinational)
- pending_mask  output  16  bit i = 1 when cnt[i] != 0 (registered state)
- overflow_err  output  1  sticky flag: a retire was seen with cnt = 0

Behaviour:
- Reset (async, rst_n low): all cnt[i] = 0, pending_mask = 0, overflow_err = 0. stall and issue follow their equations; with id_valid = 0 both are 0.
- Hazard terms:
  - raw1 = id_use_rs1 & (cnt[id_rs1] != 0) & ~(wb_load_wr & wb_dst == id_rs1 & cnt[id_rs1] == 1)
  - raw2 is the same form using rs2.
  - The exception covers a load retiring this cycle as the last pending load; the decode bypass supplies that value, so no stall.
- Structural term: full = id_is_load & (cnt[id_reg_dst] == max) & ~(wb_load_wr & wb_dst == id_reg_dst).
- Outputs:
  - stall = id_valid & (raw1 | raw2 | full).
  - issue = id_valid & ~stall & ~ex_hold.
  - ex_hold does not assert stall; it only suppresses issue.
- Counter update, per register i, each rising edge:
  - inc = issue & id_is_load & (id_reg_dst == i); dec = wb_load_wr & (wb_dst == i).
  - inc & ~dec: cnt + 1. dec & ~inc: cnt - 1. Both: unchanged. Neither: unchanged.
- Underflow: dec with cnt[i] == 0 leaves cnt at 0 and sets overflow_err. overflow_err clears only on reset.
- Self-dependent load (id_rs1 == id_reg_dst, reg not pending): no stall; the counter increments after issue.
- Latency:
  - A load issued in cycle N blocks a dependent reader from cycle N+1.
  - The reader issues in the same cycle the matching wb_load_wr is seen.
- In-order pipeline: no flush input. Loads already issued always retire; branches resolve in decode before issue.
- stall and issue have no combinational path from pending_mask's registered update in the same cycle.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined: adds output stall_cycles [31:0], an up-counter of cycles with stall = 1. It saturates at 0xFFFFFFFF and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: issue load r3 in cycle 0; in cycle 1 present an add reading rs1 = r3. Required: stall = 1 until wb_load_wr with wb_dst = 3; in that cycle stall = 0, issue = 1, and pending_mask ends at 0x0000.
- No hazard: load r3 pending; instruction reads r4/r5. Required: stall = 0, issue = 1, pending_mask = 0x0008.
- Back-to-back loads to r7 (x3, CNT_W = 2), no retire. Required: cnt[7] = 3. A 4th load to r7 gives stall = 1 (full). Retiring one load in that cycle gives stall = 0 and cnt stays 3.
- Simultaneous issue and retire on r2 (cnt = 1). Required: cnt[2] stays 1 and pending_mask bit 2 stays 1.
- ex_hold = 1 with a hazard-free load present. Required: stall = 0, issue = 0, counters unchanged.
- Reset mid-operation: cnt[3] = 2, assert rst_n = 0 asynchronously. Required: pending_mask = 0 immediately. A later wb_load_wr with wb_dst = 3 sets overflow_err = 1. With SCOREBOARD_STATS_EN, stall_cycles = 0 after reset.
